axis_divider: RTL and testbench



---
 rtl/axis_divider.sv | 119 +++++++++++
 tb/tb_axis_divider.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_divider.sv
// Iterative 32-bit radix-2 restoring divider with valid-only operand/result channels.
// Define AXIS_DIVIDER_SIGNED_EN for two's-complement signed operands; default is unsigned.
module axis_divider (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        s_axis_dividend_tvalid,
    input  logic [31:0] s_axis_dividend_tdata,
    input  logic        s_axis_divisor_tvalid,
    input  logic [31:0] s_axis_divisor_tdata,
    output logic        m_axis_dout_tvalid,
    output logic [63:0] m_axis_dout_tdata
);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] dividend_q, dividend_d;
    logic [31:0] divisor_q, divisor_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] rem_q, rem_d;
    logic [63:0] dout_q, dout_d;

    logic [31:0] divisor_mag;
    logic [32:0] rem_shift;
    logic [32:0] rem_diff;

    function automatic logic [31:0] magnitude(input logic [31:0] v);
`ifdef AXIS_DIVIDER_SIGNED_EN
        return v[31] ? (~v + 32'd1) : v;
`else
        return v;
`endif
    endfunction

    assign divisor_mag = magnitude(divisor_q);
    assign rem_shift   = {rem_q, quo_q[31]};
    assign rem_diff    = rem_shift - {1'b0, divisor_mag};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        quo_d      = quo_q;
        rem_d      = rem_q;
        dout_d     = dout_q;

        case (state_q)
            StIdle: begin
                if (s_axis_dividend_tvalid && s_axis_divisor_tvalid) begin
                    dividend_d = s_axis_dividend_tdata;
                    divisor_d  = s_axis_divisor_tdata;
                    // quo_q doubles as the dividend shift register during iteration
                    quo_d      = magnitude(s_axis_dividend_tdata);
                    rem_d      = '0;
                    cnt_d      = '0;
                    state_d    = StBusy;
                end
            end
            StBusy: begin
                if (cnt_q < 6'd32) begin
                    if (rem_shift >= {1'b0, divisor_mag}) begin
                        rem_d = rem_diff[31:0];
                        quo_d = {quo_q[30:0], 1'b1};
                    end else begin
                        rem_d = rem_shift[31:0];
                        quo_d = {quo_q[30:0], 1'b0};
                    end
                    cnt_d = cnt_q + 6'd1;
                end else if (cnt_q == 6'd32) begin
                    if (divisor_q == '0) begin
                        quo_d = '1;
                        rem_d = dividend_q;
                    end else begin
`ifdef AXIS_DIVIDER_SIGNED_EN
                        if (dividend_q[31] ^ divisor_q[31]) quo_d = ~quo_q + 32'd1;
                        if (dividend_q[31]) rem_d = ~rem_q + 32'd1;
`endif
                    end
                    cnt_d = 6'd33;
                end else begin
                    dout_d  = {quo_q, rem_q};
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            dividend_q <= '0;
            divisor_q  <= '0;
            quo_q      <= '0;
            rem_q      <= '0;
            dout_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            quo_q      <= quo_d;
            rem_q      <= rem_d;
            dout_q     <= dout_d;
        end
    end

    assign m_axis_dout_tvalid = (state_q == StDone);
    assign m_axis_dout_tdata  = dout_q;

endmodule

// File: tb/tb_axis_divider.sv
// Directed self-checking bench for axis_divider; follows AXIS_DIVIDER_SIGNED_EN like the RTL.
module tb_axis_divider;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        s_axis_dividend_tvalid;
    logic [31:0] s_axis_dividend_tdata;
    logic        s_axis_divisor_tvalid;
    logic [31:0] s_axis_divisor_tdata;
    logic        m_axis_dout_tvalid;
    logic [63:0] m_axis_dout_tdata;

    int errors = 0;
    int checks = 0;

    axis_divider dut (
        .aclk                   (aclk),
        .aresetn                (aresetn),
        .s_axis_dividend_tvalid (s_axis_dividend_tvalid),
        .s_axis_dividend_tdata  (s_axis_dividend_tdata),
        .s_axis_divisor_tvalid  (s_axis_divisor_tvalid),
        .s_axis_divisor_tdata   (s_axis_divisor_tdata),
        .m_axis_dout_tvalid     (m_axis_dout_tvalid),
        .m_axis_dout_tdata      (m_axis_dout_tdata)
    );

    always #5 aclk = ~aclk;

    // Issue one operation from idle; reports cycles from accept edge to pulse and pulse count.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int pulses, output logic [63:0] data);
        @(posedge aclk); #1;
        s_axis_dividend_tvalid = 1'b1; s_axis_dividend_tdata = a;
        s_axis_divisor_tvalid  = 1'b1; s_axis_divisor_tdata  = b;
        @(posedge aclk); #1;
        s_axis_dividend_tvalid = 1'b0; s_axis_divisor_tvalid = 1'b0;
        s_axis_dividend_tdata  = 32'hDEAD_BEEF; s_axis_divisor_tdata = 32'h0000_0001;
        lat = -1; pulses = 0; data = '0;
        for (int k = 1; k <= 60; k++) begin
            @(posedge aclk); #1;
            if (m_axis_dout_tvalid) begin
                pulses++;
                if (lat < 0) begin
                    lat  = k;
                    data = m_axis_dout_tdata;
                end
            end
        end
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        s_axis_dividend_tvalid = 1'b0; s_axis_dividend_tdata = '0;
        s_axis_divisor_tvalid  = 1'b0; s_axis_divisor_tdata  = '0;
        #23;
        checks++;
        if (m_axis_dout_tvalid !== 1'b0) begin
            errors++; $display("FAIL reset_tvalid: got %b want 0", m_axis_dout_tvalid);
        end
        checks++;
        if (m_axis_dout_tdata !== 64'd0) begin
            errors++; $display("FAIL reset_tdata: got %h want 0", m_axis_dout_tdata);
        end
        @(posedge aclk); #1;
        aresetn = 1'b1;
    endtask

    task automatic test_basic();
        int lat, pulses;
        logic [63:0] data;
        run_op(32'd100, 32'd7, lat, pulses, data);
        checks++;
        if (lat !== 34) begin
            errors++; $display("FAIL basic_latency: got %0d want 34", lat);
        end
        checks++;
        if (pulses !== 1) begin
            errors++; $display("FAIL basic_pulse_count: got %0d want 1", pulses);
        end
        checks++;
        if (data !== 64'h0000000E_00000002) begin
            errors++; $display("FAIL basic_data: got %h want 0000000e00000002", data);
        end
        checks++;
        if (m_axis_dout_tdata !== 64'h0000000E_00000002) begin
            errors++; $display("FAIL basic_hold: got %h want 0000000e00000002", m_axis_dout_tdata);
        end
    endtask

    task automatic test_sign();
        int lat, pulses;
        logic [63:0] data;
        logic [63:0] want;
`ifdef AXIS_DIVIDER_SIGNED_EN
        want = 64'hFFFFFFFD_FFFFFFFF;
`else
        want = 64'h7FFFFFFC_00000001;
`endif
        run_op(32'hFFFFFFF9, 32'd2, lat, pulses, data);
        checks++;
        if (data !== want || lat !== 34) begin
            errors++; $display("FAIL sign_div: got %h lat %0d want %h lat 34", data, lat, want);
        end
`ifdef AXIS_DIVIDER_SIGNED_EN
        want = 64'hFFFFFFFA_00000002;  // 20 / -3
        run_op(32'd20, 32'hFFFFFFFD, lat, pulses, data);
`else
        want = 64'h00000000_00000014;
        run_op(32'd20, 32'hFFFFFFFD, lat, pulses, data);
`endif
        checks++;
        if (data !== want) begin
            errors++; $display("FAIL sign_div2: got %h want %h", data, want);
        end
    endtask

    task automatic test_div_zero();
        int lat, pulses;
        logic [63:0] data;
        logic [63:0] want;
        run_op(32'd5, 32'd0, lat, pulses, data);
        checks++;
        if (data !== 64'hFFFFFFFF_00000005 || lat !== 34) begin
            errors++; $display("FAIL div_zero: got %h lat %0d want ffffffff00000005 lat 34",
                               data, lat);
        end
`ifdef AXIS_DIVIDER_SIGNED_EN
        want = 64'h80000000_00000000;
`else
        want = 64'h00000000_80000000;
`endif
        run_op(32'h80000000, 32'hFFFFFFFF, lat, pulses, data);
        checks++;
        if (data !== want) begin
            errors++; $display("FAIL overflow_case: got %h want %h", data, want);
        end
    endtask

    task automatic test_single_valid();
        int pulses = 0;
        @(posedge aclk); #1;
        s_axis_dividend_tvalid = 1'b1; s_axis_dividend_tdata = 32'd50;
        s_axis_divisor_tdata = 32'd5;
        for (int k = 0; k < 10; k++) begin
            @(posedge aclk); #1;
            if (m_axis_dout_tvalid) pulses++;
        end
        s_axis_dividend_tvalid = 1'b0;
        s_axis_divisor_tvalid  = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge aclk); #1;
            if (m_axis_dout_tvalid) pulses++;
        end
        s_axis_divisor_tvalid = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge aclk); #1;
            if (m_axis_dout_tvalid) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            errors++; $display("FAIL single_valid: got %0d pulses want 0", pulses);
        end
    endtask

    task automatic test_back_to_back();
        int p1 = -1, p2 = -1, pulses = 0, drop_at = -1;
        logic [63:0] d1 = '0, d2 = '0;
        @(posedge aclk); #1;
        s_axis_dividend_tvalid = 1'b1; s_axis_dividend_tdata = 32'd20;
        s_axis_divisor_tvalid  = 1'b1; s_axis_divisor_tdata  = 32'd4;
        @(posedge aclk); #1;
        s_axis_dividend_tdata = 32'd9; s_axis_divisor_tdata = 32'd3;
        for (int k = 1; k <= 120; k++) begin
            @(posedge aclk); #1;
            if (k == drop_at) begin
                s_axis_dividend_tvalid = 1'b0; s_axis_divisor_tvalid = 1'b0;
            end
            if (m_axis_dout_tvalid) begin
                pulses++;
                if (p1 < 0) begin
                    p1 = k; d1 = m_axis_dout_tdata; drop_at = k + 4;
                end else if (p2 < 0) begin
                    p2 = k; d2 = m_axis_dout_tdata;
                end
            end
        end
        s_axis_dividend_tvalid = 1'b0; s_axis_divisor_tvalid = 1'b0;
        checks++;
        if (p1 !== 34 || d1 !== 64'h00000005_00000000) begin
            errors++; $display("FAIL b2b_first: got %h at %0d want 0000000500000000 at 34", d1, p1);
        end
        checks++;
        if (p2 < p1 + 35 || p2 > p1 + 40 || d2 !== 64'h00000003_00000000) begin
            errors++; $display("FAIL b2b_second: got %h at %0d want 0000000300000000 at %0d..%0d",
                               d2, p2, p1 + 35, p1 + 40);
        end
        checks++;
        if (pulses !== 2) begin
            errors++; $display("FAIL b2b_pulses: got %0d want 2", pulses);
        end
    endtask

    task automatic test_reset_mid();
        int lat, pulses = 0;
        logic [63:0] data;
        @(posedge aclk); #1;
        s_axis_dividend_tvalid = 1'b1; s_axis_dividend_tdata = 32'd100;
        s_axis_divisor_tvalid  = 1'b1; s_axis_divisor_tdata  = 32'd7;
        @(posedge aclk); #1;
        s_axis_dividend_tvalid = 1'b0; s_axis_divisor_tvalid = 1'b0;
        repeat (10) @(posedge aclk);
        #2 aresetn = 1'b0;
        #1;
        checks++;
        if (m_axis_dout_tvalid !== 1'b0 || m_axis_dout_tdata !== 64'd0) begin
            errors++; $display("FAIL midreset_clear: got %b/%h want 0/0",
                               m_axis_dout_tvalid, m_axis_dout_tdata);
        end
        @(posedge aclk); #1;
        aresetn = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(posedge aclk); #1;
            if (m_axis_dout_tvalid) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            errors++; $display("FAIL midreset_no_pulse: got %0d want 0", pulses);
        end
        run_op(32'd9, 32'd3, lat, pulses, data);
        checks++;
        if (lat !== 34 || pulses !== 1 || data !== 64'h00000003_00000000) begin
            errors++; $display("FAIL midreset_fresh: got %h lat %0d pulses %0d want %h lat 34 x1",
                               data, lat, pulses, 64'h00000003_00000000);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sign();
        test_div_zero();
        test_single_valid();
        test_back_to_back();
        test_basic();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
